// File: rtl/sum_bcd_display.sv
// rtl/sum_bcd_display.sv - buffers 5-bit sums in a FIFO and shows each one as two BCD digits
// on a time-multiplexed 7-segment display, holding each value for HOLD_CYCLES cycles.
module sum_bcd_display #(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 1024,
  parameter int SCAN_DIV    = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_in_valid,
  input  logic [4:0] i_in_sum,
  output logic       o_in_ready,
  output logic [6:0] o_seg,
  output logic [1:0] o_dig_sel,
  output logic       o_busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {ST_BLANK, ST_LOAD, ST_SHOW} state_t;

  logic [4:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  state_t        r_state;
  logic [HW-1:0] r_hold_cnt;
  logic [SW-1:0] r_scan_cnt;
  logic          r_digit;
  logic [1:0]    r_tens;
  logic [3:0]    r_ones;
  logic [6:0]    r_seg;
  logic [1:0]    r_dig_sel;
  logic          r_busy;

  logic          w_push;
  logic          w_pop;
  logic          w_go_load;
  logic [CW-1:0] w_count_nxt;
  logic [4:0]    w_head;
  logic [1:0]    w_tens;
  logic [3:0]    w_ones;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // Ready is taken from the registered count only, so a full FIFO stays closed during its pop cycle.
  assign o_in_ready  = (r_count != DEPTH_C);
  assign w_push      = i_in_valid && o_in_ready;
  assign w_pop       = (r_state == ST_LOAD);
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
  assign w_head      = r_mem[r_rd_ptr];
  assign w_go_load   = (r_count != '0) &&
                       ((r_state == ST_BLANK) || ((r_state == ST_SHOW) && (r_hold_cnt == HOLD_MAX)));

  always_comb begin
    w_tens = 2'd0;
    w_ones = w_head[3:0];
    if (w_head >= 5'd30) begin
      w_tens = 2'd3;
      w_ones = 4'(w_head - 5'd30);
    end else if (w_head >= 5'd20) begin
      w_tens = 2'd2;
      w_ones = 4'(w_head - 5'd20);
    end else if (w_head >= 5'd10) begin
      w_tens = 2'd1;
      w_ones = 4'(w_head - 5'd10);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_in_sum;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_BLANK;
      r_hold_cnt <= '0;
      r_tens     <= '0;
      r_ones     <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_busy <= (w_count_nxt != '0) || w_go_load;
      case (r_state)
        ST_BLANK: if (w_go_load) r_state <= ST_LOAD;
        ST_LOAD: begin
          r_tens     <= w_tens;
          r_ones     <= w_ones;
          r_hold_cnt <= '0;
          r_state    <= ST_SHOW;
        end
        ST_SHOW: begin
          if (w_go_load) r_state <= ST_LOAD;
          else if (r_hold_cnt != HOLD_MAX) r_hold_cnt <= r_hold_cnt + HW'(1);
        end
        default: r_state <= ST_BLANK;
      endcase
    end
  end

  // Scan keeps running in BLANK so digit phase depends only on time since reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scan_cnt <= '0;
      r_digit    <= 1'b0;
      r_seg      <= '0;
      r_dig_sel  <= '0;
    end else begin
      if (r_scan_cnt == SCAN_MAX) begin
        r_scan_cnt <= '0;
        r_digit    <= ~r_digit;
      end else begin
        r_scan_cnt <= r_scan_cnt + SW'(1);
      end
      if (r_state == ST_BLANK) begin
        r_seg     <= '0;
        r_dig_sel <= 2'b00;
      end else if (!r_digit) begin
        r_seg     <= seg7(r_ones);
        r_dig_sel <= 2'b01;
      end else begin
        r_seg     <= (r_tens == 2'd0) ? 7'h00 : seg7({2'b00, r_tens});
        r_dig_sel <= 2'b10;
      end
    end
  end

  assign o_seg     = r_seg;
  assign o_dig_sel = r_dig_sel;
  assign o_busy    = r_busy;

endmodule

// File: tb/tb_sum_bcd_display.sv
// tb/tb_sum_bcd_display.sv - directed bench for sum_bcd_display
// (FIFO_DEPTH=4, HOLD_CYCLES=8, SCAN_DIV=4).
module tb_sum_bcd_display;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       i_in_valid = 1'b0;
  logic [4:0] i_in_sum = '0;
  logic       o_in_ready;
  logic [6:0] o_seg;
  logic [1:0] o_dig_sel;
  logic       o_busy;

  int n_checks = 0;
  int n_errors = 0;
  int vals[5] = '{10, 15, 20, 25, 30};

  sum_bcd_display #(.FIFO_DEPTH(4), .HOLD_CYCLES(8), .SCAN_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_in_valid (i_in_valid),
    .i_in_sum   (i_in_sum),
    .o_in_ready (o_in_ready),
    .o_seg      (o_seg),
    .o_dig_sel  (o_dig_sel),
    .o_busy     (o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: enc = 7'h3F;  1: enc = 7'h06;  2: enc = 7'h5B;  3: enc = 7'h4F;  4: enc = 7'h66;
      5: enc = 7'h6D;  6: enc = 7'h7D;  7: enc = 7'h07;  8: enc = 7'h7F;  9: enc = 7'h6F;
      default: enc = 7'h00;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input int v);
    i_in_valid = 1'b1;
    i_in_sum   = 5'(v);
    tick();
    i_in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, o_in_ready, 1);
    chk({tag, "_seg"},   o_seg,      0);
    chk({tag, "_dig"},   o_dig_sel,  0);
    chk({tag, "_busy"},  o_busy,     0);
  endtask

  // Samples n cycles: each sample must show the ones or tens digit of v, and full scan runs last 4 cycles.
  task automatic check_disp(input string tag, input int v, input int n);
    logic [6:0] seg_t = ((v / 10) == 0) ? 7'h00 : enc(v / 10);
    logic [6:0] seg_o = enc(v % 10);
    logic [1:0] prev  = 2'b00;
    bit seen_o = 1'b0;
    bit seen_t = 1'b0;
    bit first  = 1'b1;
    int run    = 0;
    for (int i = 0; i < n; i++) begin
      if (o_dig_sel == 2'b01) begin
        seen_o = 1'b1;
        chk({tag, "_ones"}, o_seg, seg_o);
      end else begin
        seen_t = 1'b1;
        chk({tag, "_tens_sel"}, o_dig_sel, 2'b10);
        chk({tag, "_tens"}, o_seg, seg_t);
      end
      if (i == 0) run = 1;
      else if (o_dig_sel != prev) begin
        if (!first) chk({tag, "_run"}, run, 4);
        first = 1'b0;
        run = 1;
      end else run++;
      prev = o_dig_sel;
      tick();
    end
    if (n >= 5) chk({tag, "_both"}, {seen_o, seen_t}, 2'b11);
  endtask

  initial begin
    int acc;

    // Asynchronous reset mid-cycle, then 100 idle cycles.
    #3 reset = 1'b1;
    #1 check_reset_outputs("rst_async");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 100; i++) begin
      check_reset_outputs("idle");
      tick();
    end

    // Single push of 23.
    push1(23);
    chk("p23_busy", o_busy, 1);
    chk("p23_ready", o_in_ready, 1);
    tick();
    tick();
    tick();
    check_disp("v23", 23, 40);

    // Leading-zero suppression and a two-digit value.
    push1(7);
    tick(); tick(); tick();
    check_disp("v07", 7, 16);
    push1(30);
    tick(); tick(); tick();
    check_disp("v30", 30, 16);

    // Backpressure: 5 is held while 10..30 are offered back to back.
    push1(5);
    tick();
    tick();
    acc = 0;
    i_in_valid = 1'b1;
    i_in_sum   = 5'd10;
    for (int c = 0; c < 10; c++) begin
      chk("bp_ready", o_in_ready, (c < 4 || c == 9) ? 1 : 0);
      if (o_in_ready) acc++;
      tick();
      if (acc < 5) i_in_sum = 5'(vals[acc]);
      else i_in_valid = 1'b0;
    end
    i_in_valid = 1'b0;
    chk("bp_accepted", acc, 5);
    chk("bp_full_again", o_in_ready, 0);
    check_disp("bp10", 10, 9);
    check_disp("bp15", 15, 9);
    check_disp("bp20", 20, 9);
    check_disp("bp25", 25, 7);
    chk("bp_busy_before_last_pop", o_busy, 1);
    tick();
    chk("bp_busy_after_last_pop", o_busy, 0);
    chk("bp_ready_after_last_pop", o_in_ready, 1);
    tick();
    check_disp("bp30", 30, 12);

    // Reset with three sums buffered and one on display.
    for (int i = 0; i < 4; i++) begin
      i_in_valid = 1'b1;
      i_in_sum   = 5'(11 + i);
      tick();
    end
    i_in_valid = 1'b0;
    tick();
    tick();
    chk("mid_busy", o_busy, 1);
    #3 reset = 1'b1;
    #1 check_reset_outputs("rst_mid");
    @(negedge clk);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check_reset_outputs("post_rst");
      tick();
    end
    push1(5);
    chk("p5_busy", o_busy, 1);
    tick();
    chk("p5_still_blank", o_dig_sel, 2'b00);
    tick();
    tick();
    check_disp("v05", 5, 16);

    // Range edges.
    push1(0);
    tick(); tick(); tick();
    check_disp("v00", 0, 12);
    push1(31);
    tick(); tick(); tick();
    check_disp("v31", 31, 12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
